sysarr_ctrl: RTL and testbench

- Sequencer for the 4x4 output-stationary systolic multiply array.
- Buffers two 4x4 operand matrices A and B written by the host, clears the array, then streams A rows into the left edge and B columns into the top edge with diagonal skew.
- Waits for the array to drain, latches all 16 accumulator outputs, and pulses done.
- Sits between the host/bus register interface and the array instance.

---
 rtl/sysarr_pkg.sv | 20 ++
 rtl/sysarr_skew.sv | 33 +++
 rtl/sysarr_ctrl.sv | 126 ++++++++++++
 tb/tb_sysarr_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarr_pkg.sv
// rtl/sysarr_pkg.sv - shared constants, FSM states and element index helper for the systolic array sequencer
package sysarr_pkg;

  localparam int SA_N  = 4;
  localparam int SA_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // LSB position of element (i,j) in a row-major packed matrix
  function automatic int idx(input int i, input int j);
    return (i * SA_N + j) * SA_DW;
  endfunction

endpackage

// File: rtl/sysarr_skew.sv
// rtl/sysarr_skew.sv - combinational diagonal skew of A rows / B columns for feed step t
module sysarr_skew
  import sysarr_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW,
  parameter int TW = $clog2(2 * N)
) (
  input  logic              en,
  input  logic [TW-1:0]     t,
  input  logic [N*N*DW-1:0] a_mat,
  input  logic [N*N*DW-1:0] b_mat,
  output logic [N*DW-1:0]   l_nxt,
  output logic [N*DW-1:0]   u_nxt
);

  // Row i carries A[i][k] and column i carries B[k][i] exactly when t == i + k
  always_comb begin
    l_nxt = '0;
    u_nxt = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t) == i + k) begin
            l_nxt[i*DW +: DW] = a_mat[idx(i, k) +: DW];
            u_nxt[i*DW +: DW] = b_mat[idx(k, i) +: DW];
          end
        end
      end
    end
  end

endmodule

// File: rtl/sysarr_ctrl.sv
// rtl/sysarr_ctrl.sv - 4x4 systolic array sequencer: operand buffers, clear/feed/drain FSM, result latch
// Optional SYSARR_CTRL_PERF_EN adds perf_cyc, the busy-cycle count of the most recent job.
module sysarr_ctrl
  import sysarr_pkg::*;
#(
  parameter int N         = SA_N,
  parameter int DW        = SA_DW,
  parameter int DRAIN_CYC = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [3:0]        wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              arr_clr,
  output logic [N*DW-1:0]   l_out,
  output logic [N*DW-1:0]   u_out,
  input  logic [N*N*DW-1:0] res_in,
  output logic [N*N*DW-1:0] res_q
`ifdef SYSARR_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cyc
`endif
);

  localparam int TW  = $clog2(2 * N);
  localparam int DCW = $clog2(DRAIN_CYC + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(2 * N - 2);
  localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_CYC - 1);

  state_t            state, state_nxt;
  logic [TW-1:0]     t_q, t_nxt, feed_t;
  logic [DCW-1:0]    dcnt, d_nxt;
  logic              feed_en;
  logic [N*N*DW-1:0] a_buf, b_buf;
  logic [N*DW-1:0]   l_nxt, u_nxt;

  // Operand buffers are host-writable only while idle and are never reset
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      if (wr_sel) b_buf[int'(wr_addr)*DW +: DW] <= wr_data;
      else        a_buf[int'(wr_addr)*DW +: DW] <= wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t_q;
    d_nxt     = dcnt;
    feed_en   = 1'b0;
    feed_t    = '0;
    case (state)
      IDLE:  if (start) state_nxt = CLR;
      CLR: begin
        state_nxt = FEED;
        t_nxt     = '0;
        feed_en   = 1'b1;
      end
      FEED: begin
        if (t_q == T_LAST) begin
          state_nxt = DRAIN;
          d_nxt     = '0;
        end else begin
          t_nxt   = t_q + TW'(1);
          feed_en = 1'b1;
          feed_t  = t_q + TW'(1);
        end
      end
      DRAIN: begin
        if (dcnt == D_LAST) state_nxt = DONE;
        else                d_nxt     = dcnt + DCW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == CLR) || (state == FEED) || (state == DRAIN);
  assign done    = (state == DONE);
  assign arr_clr = (state == CLR);

  // Edge vectors are computed one step ahead so they are registered into the cycle they belong to
  sysarr_skew #(.N(N), .DW(DW), .TW(TW)) u_skew (
    .en    (feed_en),
    .t     (feed_t),
    .a_mat (a_buf),
    .b_mat (b_buf),
    .l_nxt (l_nxt),
    .u_nxt (u_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      t_q   <= '0;
      dcnt  <= '0;
      l_out <= '0;
      u_out <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      t_q   <= t_nxt;
      dcnt  <= d_nxt;
      l_out <= l_nxt;
      u_out <= u_nxt;
      if (state == DRAIN && dcnt == D_LAST) res_q <= res_in;
    end
  end

`ifdef SYSARR_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cyc <= '0;
    end else if (state == IDLE && start) begin
      perf_cyc <= '0;
    end else if (busy && perf_cyc != '1) begin
      perf_cyc <= perf_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sysarr_ctrl.sv
// tb/tb_sysarr_ctrl.sv - scoreboard bench for sysarr_ctrl with a behavioural 4x4 output-stationary array
module tb_sysarr_ctrl;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = N * N * DW;
  localparam int FEED_OBS = 2 * N - 1 + 7;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic              wr_sel = 1'b0;
  logic [3:0]        wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              start = 1'b0;
  logic              busy, done, arr_clr;
  logic [N*DW-1:0]   l_out, u_out;
  logic [RW-1:0]     res_in, res_q;
`ifdef SYSARR_CTRL_PERF_EN
  logic [31:0]       perf_cyc;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int feed_left = 0;
  int n_done;

  logic [RW-1:0]     res_exp_q[$];
  logic [2*N*DW-1:0] feed_q[$];
  logic [2*N*DW-1:0] fe;
  logic [RW-1:0]     re;
  logic [DW-1:0]     a_m[N][N];
  logic [DW-1:0]     b_m[N][N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sysarr_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .arr_clr (arr_clr),
    .l_out   (l_out),
    .u_out   (u_out),
    .res_in  (res_in),
    .res_q   (res_q)
`ifdef SYSARR_CTRL_PERF_EN
    ,
    .perf_cyc(perf_cyc)
`endif
  );

  // Behavioural array: operands shift right/down, each PE accumulates its products
  logic [DW-1:0] pa[N][N], pb[N][N], acc[N][N];
  logic [DW-1:0] ai, bi;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ai = (j == 0) ? l_out[i*DW +: DW] : pa[i][j-1];
        bi = (i == 0) ? u_out[j*DW +: DW] : pb[i-1][j];
        if (arr_clr) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= ai;
          pb[i][j]  <= bi;
          acc[i][j] <= acc[i][j] + ai * bi;
        end
      end
    end
  end

  always_comb begin
    res_in = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        res_in[(i*N+j)*DW +: DW] = acc[i][j];
  end

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2*N*DW-1:0] exp_lu(input int t);
    logic [N*DW-1:0] l, u;
    l = '0;
    u = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < N) l[i*DW +: DW] = a_m[i][t-i];
      if (t - i >= 0 && t - i < N) u[i*DW +: DW] = b_m[t-i][i];
    end
    return {l, u};
  endfunction

  function automatic logic [RW-1:0] exp_res();
    logic [RW-1:0] r;
    logic [DW-1:0] s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) s = s + a_m[i][k] * b_m[k][j];
        r[(i*N+j)*DW +: DW] = s;
      end
    return r;
  endfunction

  // Monitor: edge vectors for 14 cycles after each clear, results on every done
  always @(negedge clk) begin
    if (!rst) begin
      res_exp_q.delete();
      feed_q.delete();
      feed_left = 0;
    end else begin
      if (feed_left > 0) begin
        if (feed_q.size() == 0) begin
          chk("feed_unexpected", RW'({l_out, u_out}), RW'(0));
        end else begin
          fe = feed_q.pop_front();
          chk("feed_lu", RW'({l_out, u_out}), RW'(fe));
        end
        feed_left--;
      end
      if (arr_clr) feed_left = FEED_OBS;
      if (done) begin
        done_cnt++;
        chk("done_latency", RW'(cyc - start_cyc), RW'(16));
        if (res_exp_q.size() == 0) begin
          chk("done_unexpected", RW'(done), RW'(0));
        end else begin
          re = res_exp_q.pop_front();
          chk("res_q", res_q, re);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int addr, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 4'(addr);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic load();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        wr(1'b0, i*N+j, a_m[i][j]);
        wr(1'b1, i*N+j, b_m[i][j]);
      end
  endtask

  task automatic go();
    for (int t = 0; t < FEED_OBS; t++) feed_q.push_back(exp_lu(t));
    res_exp_q.push_back(exp_res());
    start = 1'b1;
    tick();
    start_cyc = cyc - 1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n0;
    n0 = done_cnt;
    for (int k = 0; k < 40 && done_cnt == n0; k++) tick();
    if (done_cnt == n0) chk("done_timeout", RW'(done_cnt), RW'(n0 + 1));
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", RW'(busy), RW'(0));
    chk("rst_done", RW'(done), RW'(0));
    chk("rst_arr_clr", RW'(arr_clr), RW'(0));
    chk("rst_lu", RW'({l_out, u_out}), RW'(0));
    chk("rst_res_q", res_q, RW'(0));
`ifdef SYSARR_CTRL_PERF_EN
    chk("rst_perf", RW'(perf_cyc), RW'(0));
`endif
    rst = 1'b1;
    tick();

    // Identity A times B[i][j] = 4i+j+1
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = (i == j) ? 32'd1 : 32'd0;
        b_m[i][j] = 32'(4*i + j + 1);
      end
    load();
    go();
    wait_done();
`ifdef SYSARR_CTRL_PERF_EN
    chk("perf_after_done", RW'(perf_cyc), RW'(15));
`endif

    // Skew pattern, with a locked write at cycle 4 and a stray start at cycle 5
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = 32'(16 + 4*i + j);
        b_m[i][j] = '0;
      end
    load();
    go();
`ifdef SYSARR_CTRL_PERF_EN
    chk("perf_cleared_on_start", RW'(perf_cyc), RW'(0));
`endif
    repeat (3) tick();
    wr(1'b0, 0, 32'd99);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    n_done = done_cnt;
    repeat (25) tick();
    chk("no_second_job", RW'(done_cnt), RW'(n_done));
    chk("idle_busy", RW'(busy), RW'(0));

    // B = identity exposes the A buffer: A[0][0] must still be 16
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        b_m[i][j] = (i == j) ? 32'd1 : 32'd0;
        wr(1'b1, i*N+j, b_m[i][j]);
      end
    go();
    wait_done();

    // Reset during FEED t=2
    go();
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", RW'(busy), RW'(0));
    chk("midrst_done", RW'(done), RW'(0));
    chk("midrst_arr_clr", RW'(arr_clr), RW'(0));
    chk("midrst_lu", RW'({l_out, u_out}), RW'(0));
    chk("midrst_res_q", res_q, RW'(0));
    repeat (2) tick();
    rst = 1'b1;
    n_done = done_cnt;
    repeat (3) tick();
    chk("postrst_busy", RW'(busy), RW'(0));
    chk("postrst_no_done", RW'(done_cnt), RW'(n_done));
    go();
    wait_done();
`ifdef SYSARR_CTRL_PERF_EN
    chk("perf_final", RW'(perf_cyc), RW'(15));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
